udp_recv: RTL
=============

// Module: udp_recv
// PURPOSE
//   GMII-side UDP/IPv4 receiver; the receive counterpart of the UDP send path.
//   Sits on eth_rxc and parses the preamble, SFD, Ethernet, IPv4 and UDP headers.
//   Filters frames addressed to this board and packs the UDP payload into
//   big-endian 32-bit words, ready for an RX FIFO. FCS is not checked.
// PARAMETERS
//   BOARD_MAC_ADDR  48'h00_11_22_33_44_55  accepted dest MAC (48'hFF..FF also accepted)
//   BOARD_IP_ADDR   {192,168,1,10}         accepted dest IPv4 address
// PORTS
//   eth_rxc       in   1   GMII receive clock; all logic is on its rising edge
//   rst_n         in   1   reset, asynchronous, active-low
//   eth_rxdv      in   1   GMII receive data valid
//   eth_rxd       in   8   GMII receive data byte
//   rec_en        out  1   one-cycle strobe: rec_data holds a valid word
//   rec_data      out  32  payload word; first received byte is in [31:24]
//   rec_pkt_done  out  1   one-cycle strobe: payload complete
//   rec_byte_num  out  16  payload byte count (UDP length - 8); valid from UDP header end
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; counters 0.
//   FSM states and transitions (cnt = byte counter within the current state):
//   - IDLE: rxdv=1 and rxd=8'h55 -> PREAMBLE, cnt=1.
//   - PREAMBLE: require rxd=55 for cnt 1..6.
//     At cnt 7, rxd=D5 -> ETH_HEAD; any other byte -> RX_END.
//   - ETH_HEAD (14 B): bytes 0-5 = dest MAC; compare at byte 5.
//     Bytes 12-13 must be 16'h0800. Any mismatch -> RX_END; otherwise -> IP_HEAD.
//   - IP_HEAD: byte 0 must be 8'h4x; header length = 4*x (x<5 -> RX_END).
//     Byte 9 must be 8'd17. Bytes 16-19 = dest IP; compare at byte 19.
//     At byte 4*x-1 -> UDP_HEAD (options are skipped).
//   - UDP_HEAD (8 B): bytes 4-5 = UDP length L. L<8 -> RX_END.
//     At byte 7, rec_byte_num<=L-8; if L=8, pulse rec_pkt_done -> RX_END.
//     Otherwise -> RX_DATA.
//   - RX_DATA: shift each byte into the word; rec_en=1 the cycle after the 4th byte of a word.
//     Last byte (count = rec_byte_num): a partial word is left-aligned, unused low bytes=0.
//     rec_en and rec_pkt_done pulse together the cycle after the last byte -> RX_END.
//   - RX_END: discard padding/FCS until rxdv=0, then -> IDLE.
//   Latency: one eth_rxc from the final byte of a word to rec_en.
//   rec_data holds its value between strobes.
//   rxdv falls in any state other than IDLE/RX_END:
//     -> IDLE next cycle; no rec_pkt_done; a partial word is never emitted.
//   Bytes received by a new frame before IDLE is reached are ignored.
//   The dest UDP port is not filtered; rec_byte_num is not cleared between frames.
//   Arithmetic: 16-bit counters; header fields are assembled MSB first.
//   rst_n low mid-frame: immediate return to reset values; no strobes.
// TESTING
//   1. Unicast frame, 10-byte payload 00..09 -> rec_en x3:
//      00010203, 04050607, 08090000; rec_pkt_done with third; rec_byte_num=10.
//   2. Broadcast MAC, 4-byte payload DEADBEEF -> one rec_en DEADBEEF + rec_pkt_done.
//   3. Wrong dest IP 192.168.1.11 or protocol 6 -> no rec_en, no rec_pkt_done; IDLE after rxdv=0.
//   4. rxdv dropped after 6 of 12 payload bytes -> one rec_en only, no done;
//      back-to-back next frame is received correctly.
//   5. UDP length=8 -> rec_pkt_done pulse, rec_byte_num=0, no rec_en.
//      IHL=6 with 4 option bytes -> payload still parsed correctly.
//   6. rst_n asserted mid-payload -> all outputs 0 at once; next frame is received normally.

Source files
------------

// File: rtl/udp_recv.sv
// udp_recv: GMII-side UDP/IPv4 receiver.
// Parses preamble/SFD, Ethernet, IPv4 and UDP headers on eth_rxc. It drops
// frames not addressed to this board (unicast MAC or broadcast, plus
// dest IP). It packs the UDP payload into big-endian 32-bit words. FCS is not
// checked; the UDP destination port is not filtered.
// Ports:
//   eth_rxc      in   GMII receive clock (rising edge)
//   rst_n        in   asynchronous active-low reset
//   eth_rxdv     in   GMII receive data valid
//   eth_rxd      in   GMII receive byte
//   rec_en       out  one-cycle strobe, rec_data holds a valid word
//   rec_data     out  payload word, first received byte in [31:24]
//   rec_pkt_done out  one-cycle strobe, payload complete
//   rec_byte_num out  payload byte count (UDP length - 8)
module udp_recv #(
  parameter logic [47:0] BOARD_MAC_ADDR = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP_ADDR  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        eth_rxc,
  input  logic        rst_n,
  input  logic        eth_rxdv,
  input  logic [7:0]  eth_rxd,
  output logic        rec_en,
  output logic [31:0] rec_data,
  output logic        rec_pkt_done,
  output logic [15:0] rec_byte_num
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StPreamble = 3'd1;
  localparam logic [2:0] StEthHead  = 3'd2;
  localparam logic [2:0] StIpHead   = 3'd3;
  localparam logic [2:0] StUdpHead  = 3'd4;
  localparam logic [2:0] StRxData   = 3'd5;
  localparam logic [2:0] StRxEnd    = 3'd6;

  logic [2:0]  r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [39:0] r_mac;       // first five dest MAC bytes
  logic [23:0] r_ip;        // first three dest IP bytes
  logic [5:0]  r_ihl_last;  // index of the last IP header byte (4*IHL - 1)
  logic [7:0]  r_len_hi;
  logic [15:0] r_udp_len;
  logic [31:0] r_word;      // current payload word, left-aligned, low bytes zero

  logic [47:0] w_dmac;
  logic [31:0] w_dip;
  logic [15:0] w_ulen;
  logic [5:0]  w_ihl_last;
  logic [31:0] w_word;
  logic        w_last;
  logic        w_emit, w_done, w_set_len;

  assign w_cnt_inc  = r_cnt + 16'd1;
  assign w_dmac     = {r_mac, eth_rxd};
  assign w_dip      = {r_ip, eth_rxd};
  assign w_ulen     = {r_len_hi, eth_rxd};
  assign w_ihl_last = {eth_rxd[3:0], 2'b00} - 6'd1;
  assign w_last     = (w_cnt_inc == rec_byte_num);

  // Merge the incoming byte into the word at its position; unused bytes stay zero.
  always_comb begin
    w_word = 32'h0;
    case (r_cnt[1:0])
      2'd0:    w_word = {eth_rxd, 24'h0};
      2'd1:    w_word = {r_word[31:24], eth_rxd, 16'h0};
      2'd2:    w_word = {r_word[31:16], eth_rxd, 8'h0};
      default: w_word = {r_word[31:8], eth_rxd};
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_done      = 1'b0;
    w_set_len   = 1'b0;
    if (!eth_rxdv && r_state != StIdle && r_state != StRxEnd) begin
      // Truncated frame: abandon it silently, partial word included.
      w_state_nxt = StIdle;
      w_cnt_nxt   = 16'd0;
    end else begin
      case (r_state)
        StIdle: begin
          w_cnt_nxt = 16'd0;
          if (eth_rxdv && eth_rxd == 8'h55) begin
            w_state_nxt = StPreamble;
            w_cnt_nxt   = 16'd1;
          end
        end
        StPreamble: begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt < 16'd7) begin
            if (eth_rxd != 8'h55) w_state_nxt = StRxEnd;
          end else if (eth_rxd == 8'hD5) begin
            w_state_nxt = StEthHead;
            w_cnt_nxt   = 16'd0;
          end else begin
            w_state_nxt = StRxEnd;
          end
        end
        StEthHead: begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == 16'd5 && w_dmac != BOARD_MAC_ADDR && w_dmac != 48'hFFFF_FFFF_FFFF) begin
            w_state_nxt = StRxEnd;
          end else if (r_cnt == 16'd12 && eth_rxd != 8'h08) begin
            w_state_nxt = StRxEnd;
          end else if (r_cnt == 16'd13) begin
            w_cnt_nxt   = 16'd0;
            w_state_nxt = (eth_rxd == 8'h00) ? StIpHead : StRxEnd;
          end
        end
        StIpHead: begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == 16'd0) begin
            if (eth_rxd[7:4] != 4'h4 || eth_rxd[3:0] < 4'd5) w_state_nxt = StRxEnd;
          end else if (r_cnt == 16'd9 && eth_rxd != 8'd17) begin
            w_state_nxt = StRxEnd;
          end else if (r_cnt == 16'd19 && w_dip != BOARD_IP_ADDR) begin
            w_state_nxt = StRxEnd;
          end else if (r_cnt == {10'd0, r_ihl_last}) begin
            w_state_nxt = StUdpHead;
            w_cnt_nxt   = 16'd0;
          end
        end
        StUdpHead: begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == 16'd5 && w_ulen < 16'd8) begin
            w_state_nxt = StRxEnd;
          end else if (r_cnt == 16'd7) begin
            w_set_len = 1'b1;
            w_cnt_nxt = 16'd0;
            if (r_udp_len == 16'd8) begin
              w_done      = 1'b1;
              w_state_nxt = StRxEnd;
            end else begin
              w_state_nxt = StRxData;
            end
          end
        end
        StRxData: begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt[1:0] == 2'd3 || w_last) w_emit = 1'b1;
          if (w_last) begin
            w_done      = 1'b1;
            w_state_nxt = StRxEnd;
            w_cnt_nxt   = 16'd0;
          end
        end
        StRxEnd: begin
          w_cnt_nxt = 16'd0;
          if (!eth_rxdv) w_state_nxt = StIdle;
        end
        default: begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge eth_rxc or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Header field capture; only meaningful while the byte is valid.
  always_ff @(posedge eth_rxc or negedge rst_n) begin
    if (!rst_n) begin
      r_mac      <= 40'h0;
      r_ip       <= 24'h0;
      r_ihl_last <= 6'd0;
      r_len_hi   <= 8'h0;
      r_udp_len  <= 16'h0;
      r_word     <= 32'h0;
    end else if (eth_rxdv) begin
      if (r_state == StEthHead && r_cnt < 16'd5) r_mac <= {r_mac[31:0], eth_rxd};
      if (r_state == StIpHead && r_cnt == 16'd0) r_ihl_last <= w_ihl_last;
      if (r_state == StIpHead && r_cnt >= 16'd16 && r_cnt <= 16'd18) begin
        r_ip <= {r_ip[15:0], eth_rxd};
      end
      if (r_state == StUdpHead && r_cnt == 16'd4) r_len_hi <= eth_rxd;
      if (r_state == StUdpHead && r_cnt == 16'd5) r_udp_len <= w_ulen;
      if (r_state == StRxData) r_word <= w_word;
    end
  end

  always_ff @(posedge eth_rxc or negedge rst_n) begin
    if (!rst_n) begin
      rec_en       <= 1'b0;
      rec_data     <= 32'h0;
      rec_pkt_done <= 1'b0;
      rec_byte_num <= 16'h0;
    end else begin
      rec_en       <= w_emit;
      rec_pkt_done <= w_done;
      if (w_emit) rec_data <= w_word;
      if (w_set_len) rec_byte_num <= r_udp_len - 16'd8;
    end
  end

endmodule
